// File: rtl/qpu_ifu_ifetch.sv
// QPU IFU instruction-fetch front end.
// Fetches one instruction at a time into a single-entry IR, predicts the next
// fetch PC statically from the mini-decoder fields, stalls IR issue on a
// register-read hazard and honours pipeline flushes from the EXU.
module qpu_ifu_ifetch #(
  parameter int PC_SIZE    = 32,
  parameter int INSTR_SIZE = 32,
  parameter int XLEN       = 32,
  parameter int RFIDX_W    = 5,
  parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_valid,
  input  logic                  ifu_req_ready,
  output logic [PC_SIZE-1:0]    ifu_req_pc,
  input  logic                  ifu_rsp_valid,
  output logic                  ifu_rsp_ready,
  input  logic [INSTR_SIZE-1:0] ifu_rsp_instr,
  output logic [INSTR_SIZE-1:0] mini_instr,
  input  logic                  dec_rs1en,
  input  logic                  dec_rs2en,
  input  logic [RFIDX_W-1:0]    dec_rs1idx,
  input  logic [RFIDX_W-1:0]    dec_rs2idx,
  input  logic                  dec_bxx,
  input  logic [XLEN-1:0]       dec_bjp_imm,
  input  logic                  busy_valid,
  input  logic [RFIDX_W-1:0]    busy_rdidx,
  output logic                  ir_valid,
  input  logic                  ir_ready,
  output logic [INSTR_SIZE-1:0] ir_instr,
  output logic [PC_SIZE-1:0]    ir_pc,
  output logic                  ir_prdt_taken,
  input  logic                  flush_req,
  input  logic [PC_SIZE-1:0]    flush_pc,
  output logic                  flush_ack
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e                  state_q, state_d;
  logic [PC_SIZE-1:0]      fetchPc_q, fetchPc_d;
  logic                    irFull_q, irFull_d;
  logic [INSTR_SIZE-1:0]   irInstr_q, irInstr_d;
  logic [PC_SIZE-1:0]      irPc_q, irPc_d;
  logic                    irPrdt_q, irPrdt_d;
  logic                    drop_q, drop_d;
  // Set for the one cycle after an IR load, while the decoder looks at the new IR
  // and the predicted PC is being registered; no request goes out in that cycle.
  logic                    updPc_q, updPc_d;

  logic                    prdtTaken;
  logic [PC_SIZE-1:0]      predPc;
  logic                    hazard;
  logic                    irFire;
  logic                    reqFire;
  logic                    rspFire;

  // Static prediction, register-read interlock and handshake qualifiers.
  always_comb begin
    prdtTaken = dec_bxx & dec_bjp_imm[XLEN-1];
    predPc    = prdtTaken ? (irPc_q + dec_bjp_imm[PC_SIZE-1:0])
                          : (irPc_q + PC_SIZE'(4));
    hazard    = (dec_rs1en & busy_valid & (busy_rdidx == dec_rs1idx) & (dec_rs1idx != '0))
              | (dec_rs2en & busy_valid & (busy_rdidx == dec_rs2idx) & (dec_rs2idx != '0));
    ir_valid      = irFull_q & ~hazard;
    irFire        = ir_valid & ir_ready;
    ifu_req_valid = (state_q == REQ) & ~updPc_q;
    ifu_req_pc    = fetchPc_q;
    reqFire       = ifu_req_valid & ifu_req_ready;
    ifu_rsp_ready = (state_q == WAIT_RSP) & (drop_q | ~irFull_q | irFire);
    rspFire       = ifu_rsp_ready & ifu_rsp_valid;
    flush_ack     = flush_req & ~rst;
    mini_instr    = irInstr_q;
    ir_instr      = irInstr_q;
    ir_pc         = irPc_q;
    ir_prdt_taken = updPc_q ? prdtTaken : irPrdt_q;
  end

  // Next-state logic: fetch sequencing first, then flush overrides everything.
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    irFull_d  = irFull_q;
    irInstr_d = irInstr_q;
    irPc_d    = irPc_q;
    irPrdt_d  = irPrdt_q;
    drop_d    = drop_q;
    updPc_d   = updPc_q;

    if (irFire) begin
      irFull_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        state_d   = REQ;
        fetchPc_d = RESET_PC;
      end
      REQ: begin
        if (updPc_q) begin
          fetchPc_d = predPc;
          irPrdt_d  = prdtTaken;
          updPc_d   = 1'b0;
        end else if (reqFire) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (rspFire) begin
          state_d = REQ;
          if (drop_q) begin
            drop_d = 1'b0;
          end else begin
            irFull_d  = 1'b1;
            irInstr_d = ifu_rsp_instr;
            irPc_d    = fetchPc_q;
            updPc_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush_req) begin
      fetchPc_d = flush_pc;
      irFull_d  = 1'b0;
      irInstr_d = irInstr_q;
      irPc_d    = irPc_q;
      irPrdt_d  = irPrdt_q;
      updPc_d   = 1'b0;
      if (reqFire || ((state_q == WAIT_RSP) && !rspFire)) begin
        drop_d  = 1'b1;
        state_d = WAIT_RSP;
      end else begin
        drop_d  = 1'b0;
        state_d = REQ;
      end
    end
  end

  // State and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      fetchPc_q <= RESET_PC;
      irFull_q  <= 1'b0;
      irInstr_q <= '0;
      irPc_q    <= '0;
      irPrdt_q  <= 1'b0;
      drop_q    <= 1'b0;
      updPc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      fetchPc_q <= fetchPc_d;
      irFull_q  <= irFull_d;
      irInstr_q <= irInstr_d;
      irPc_q    <= irPc_d;
      irPrdt_q  <= irPrdt_d;
      drop_q    <= drop_d;
      updPc_q   <= updPc_d;
    end
  end

endmodule
